// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder
// Data-memory responder for the MIPS core. Serves MemRead/MemWrite requests
// from an internal word-addressed RAM with a fixed number of wait states. It
// raises Stall so the single-cycle core freezes PC and register write-back
// until the access completes.
//
// Ports:
//   Clk        in   1   system clock, rising-edge
//   Res        in   1   synchronous reset, active-high
//   MemRead    in   1   load request
//   MemWrite   in   1   store request (wins if both are asserted)
//   Addr       in  32   byte address; bits [DEPTH_LOG2+1:2] select the word
//   WriteData  in  32   store data
//   ReadData   out 32   registered load data, held until the next completed read
//   Stall      out  1   core must hold PC and suppress RegWrite this cycle
//   Ready      out  1   one-cycle pulse in the cycle the access completes
//   AlignErr   out  1   misaligned request presented while idle
module mips_dmem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Res,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Ready,
    output logic        AlignErr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Reject parameter values the counter and address slicing cannot support.
    generate
        if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait
            $error("mips_dmem_responder: WAIT_STATES must be in 1..15");
        end
        if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 16) begin : g_bad_depth
            $error("mips_dmem_responder: DEPTH_LOG2 must be in 2..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic                    lat_write;
    logic [DEPTH_LOG2-1:0]   lat_index;
    logic [31:0]             lat_data;
    logic [31:0]             mem [DEPTH];

    logic                    req;
    logic                    aligned;
    logic                    accept;
    logic                    commit;
    logic [DEPTH_LOG2-1:0]   index;
    logic                    unused_addr;

    assign req     = MemRead | MemWrite;
    assign aligned = (Addr[1:0] == 2'b00);
    assign index   = Addr[DEPTH_LOG2+1:2];
    assign accept  = (state == IDLE) && req && aligned;
    // The access takes effect on the edge that ends the last WAIT cycle.
    assign commit  = (state == WAIT) && (cnt == 4'd1);

    // Upper address bits are deliberately ignored so addresses wrap.
    assign unused_addr = ^Addr[31:DEPTH_LOG2+2];

    // State register and wait-state counter.
    always_ff @(posedge Clk) begin
        if (Res) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= 4'(WAIT_STATES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Request capture; the core's inputs are ignored after acceptance.
    always_ff @(posedge Clk) begin
        if (accept) begin
            lat_write <= MemWrite;
            lat_index <= index;
            lat_data  <= WriteData;
        end
    end

    // RAM write port. Reset on the commit edge must drop the pending store.
    always_ff @(posedge Clk) begin
        if (!Res && commit && lat_write) begin
            mem[lat_index] <= lat_data;
        end
    end

    // Load data register; only completed reads update it.
    always_ff @(posedge Clk) begin
        if (Res) begin
            ReadData <= 32'd0;
        end else if (commit && !lat_write) begin
            ReadData <= mem[lat_index];
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (cnt == 4'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs. Stall is combinational in IDLE so the requesting instruction
    // is frozen in the very cycle it presents the request.
    always_comb begin
        Stall    = 1'b0;
        Ready    = 1'b0;
        AlignErr = 1'b0;
        case (state)
            IDLE: begin
                Stall    = req & aligned;
                AlignErr = req & ~aligned;
            end
            WAIT:    Stall = 1'b1;
            DONE:    Ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
- Data-memory responder for the MIPS core. It serves the core's MemRead/MemWrite requests from an internal word-addressed RAM.
- Each access takes a fixed, parameterised number of wait states. The block drives Stall back to the datapath so the single-cycle core freezes PC and register write-back until the access completes.
- It replaces the zero-latency data memory inside DataPath, so slower memory timing can be modelled and verified.

Parameters:
- DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (default 256 words). Legal range 2..16.
- WAIT_STATES, 2, number of WAIT cycles per access. Legal range 1..15; a value of 0 is illegal and is rejected at elaboration.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Res  input  1  synchronous reset, active-high.
- MemRead  input  1  read request from ControlUnit.
- MemWrite  input  1  write request from ControlUnit.
- Addr  input  32  byte address (ALU result).
- WriteData  input  32  store data (ReadData2 path).
- ReadData  output  32  registered load data (MemOut path).
- Stall  output  1  high means the core must hold PC and suppress RegWrite this cycle.
- Ready  output  1  one-cycle pulse in the cycle the access completes.
- AlignErr  output  1  high in the cycle a misaligned request is presented in IDLE.

Behaviour:
- Reset (Res high at a rising Clk edge):
  - state=IDLE, cnt=0, ReadData=0, Ready=0, Stall=0, AlignErr=0.
  - RAM contents are not reset.
  - A latched request in flight is discarded; a pending write is never committed.
- States: IDLE, WAIT, DONE.
- Request definitions:
  - req = MemRead | MemWrite.
  - aligned = (Addr[1:0] == 2'b00).
  - Word index = Addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo the depth.
- IDLE:
  - If req & aligned: Stall=1 combinationally in the same cycle. Latch op, index and WriteData. Load cnt=WAIT_STATES. Next state is WAIT.
  - If req & !aligned: AlignErr=1 combinationally, Stall=0, no RAM access, ReadData unchanged, remain in IDLE.
  - If no req: outputs idle.
- WAIT:
  - Stall=1. cnt decrements by 1 each cycle.
  - When cnt==1, at that clock edge:
    - A write commits the latched WriteData to RAM[index].
    - A read loads ReadData <= RAM[index].
    - Next state is DONE.
  - Request inputs are ignored while in WAIT, so the latched values govern the access.
- DONE:
  - Stall=0, Ready=1. ReadData is valid and the core completes the instruction at the end of this cycle.
  - Next state is always IDLE.
  - req inputs seen in DONE belong to the completing instruction and are ignored.
- Latency: request at cycle T. Stall is high for cycles T..T+WAIT_STATES (WAIT_STATES+1 cycles). Ready and valid data appear at T+WAIT_STATES+1.
- Back-to-back accesses: the first cycle a new request can be accepted is T+WAIT_STATES+2 (IDLE). There is exactly one non-stalled DONE cycle between accesses.
- MemRead & MemWrite together: treated as a write. ReadData is not updated.
- ReadData holds its value until the next completed read; writes and misaligned requests leave it unchanged.
- Stall, Ready and AlignErr are never high together with each other, except in the case Stall=1 with AlignErr=0.

Test Plan:
- Reset then idle: hold Res for 2 cycles with MemRead=MemWrite=0 → ReadData=0, Stall=0, Ready=0, AlignErr=0 on every cycle after reset.
- Write then read, WAIT_STATES=2:
  - Write Addr=0x10, WriteData=0xDEADBEEF at T → Stall high T..T+2, Ready at T+3.
  - Read 0x10 at T+4 → Stall high T+4..T+6, Ready at T+7 with ReadData=0xDEADBEEF.
- Misaligned access: MemRead with Addr=0x13 → AlignErr=1 that cycle, Stall=0, state stays IDLE, ReadData unchanged.
- Wrap-around, DEPTH_LOG2=8: write 0x12345678 to Addr=0x404, then read Addr=0x004 → ReadData=0x12345678.
- Simultaneous MemRead & MemWrite: Addr=0x20, WriteData=0xA5A5A5A5 → treated as a write. ReadData keeps its prior value; a later read of 0x20 returns 0xA5A5A5A5.
- Reset mid-operation: write 0xCAFEF00D to 0x30, assert Res during the first WAIT cycle → Stall=0, Ready=0 next cycle; a later read of 0x30 returns the previous contents, not 0xCAFEF00D.
